cpu_core: RTL and testbench
===========================

CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter WORD_WIDTH, default 16, meaning datapath/register width; SHALL be at least 16.
REQ-002 Parameter NUM_REGS, default 16, meaning register count; SHALL be a power of two from 2 to 16, register fields indexed modulo NUM_REGS.
REQ-003 Parameter ADDR_WIDTH, default 8, meaning instruction-pointer width.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 do_reset_n  in  1  reset, synchronous and active-low.
REQ-006 imem_req/imem_addr  out  1/ADDR_WIDTH  fetch request and instruction address.
REQ-007 imem_ack/imem_data  in  1/16  fetch acknowledge and instruction word.
REQ-008 port_req/port_we  out  1/1  port transaction request and write flag (1=OUT, 0=IN).
REQ-009 port_addr/port_wdata  out  WORD_WIDTH/WORD_WIDTH  port address and write data.
REQ-010 port_ack/port_rdata  in  1/WORD_WIDTH  port acknowledge and read data.
REQ-011 halted  out  1  core stopped on HALT.
REQ-012 state  out  3  current FSM state encoding, for debug.

Function
REQ-013 Instruction fields SHALL be: opcode[15:12], rd[11:8], ra[7:4], rb[3:0], imm8[7:0], imm4[3:0].
REQ-014 Opcodes SHALL be: 0 NOP, 1 LOADLO, 2 IN, 3 OUT, 4 JMP, 5 BR, 6 HALT, 7 NOP; 8-15 ALU with aluop=opcode[2:0].
REQ-015 ALU ops SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by 1, 6 SHR logical by 1, 7 SLT unsigned (result 1/0); results truncated to WORD_WIDTH; rd<=R[ra] op R[rb].
REQ-016 Register 0 SHALL always read zero; writes to it SHALL be discarded.
REQ-017 FSM states SHALL be FETCH, REGLOAD, EXEC, WRITEBACK, NEXT, HALTED.
REQ-018 FETCH: imem_req=1 and imem_addr=PC; when imem_ack=1 the same cycle, latch imem_data and go REGLOAD; otherwise stay.
REQ-019 REGLOAD: latch R[ra], R[rb], R[rd] in one cycle; go EXEC.
REQ-020 EXEC: ALU/LOADLO/NOP/JMP/BR complete in one cycle; IN/OUT hold port_req=1 until port_ack=1, then go WRITEBACK; HALT goes HALTED.
REQ-021 Port address SHALL be R[ra]+zero-extended imm4 modulo 2^WORD_WIDTH; OUT drives port_wdata=R[rd], port_we=1.
REQ-022 WRITEBACK: ALU writes result, LOADLO writes zero-extended imm8, IN writes port_rdata latched at ack; other opcodes write nothing.
REQ-023 NEXT: JMP sets PC=PC+sign-extended imm8; BR does the same if R[rd]!=0, else PC+1; all others PC+1; arithmetic modulo 2^ADDR_WIDTH (wraps); go FETCH.
REQ-024 Minimum latency SHALL be 5 cycles per instruction; each imem/port wait cycle adds exactly one.
REQ-025 imem_ack outside FETCH and port_ack outside an IN/OUT EXEC SHALL be ignored.
REQ-026 port_req and imem_req SHALL never be high together, and each SHALL drop the cycle after its ack.
REQ-027 HALTED: halted=1, no requests, left only by reset.

Reset
REQ-028 With do_reset_n=0 at a rising edge: PC=0, state=FETCH, all registers 0, imem_req=0, port_req=0, port_we=0, halted=0, port_addr/port_wdata=0 at the next edge.
REQ-029 Reset mid-transaction SHALL abort it with no register write; first request after release SHALL be imem fetch of address 0.

Structure
REQ-030 Opcode, aluop and state encodings SHALL live in the shared parameters include file.
REQ-031 Register storage SHALL be sub-module cpu_regfile (two read ports, one write port, zero register); ALU may be inline.

Verification
REQ-032 Ack always 1: LOADLO R1,0x05; LOADLO R2,0x03; SUB R3,R1,R2 -> R3=2 after 15 cycles, PC=3.
REQ-033 imem_ack delayed 3 cycles per fetch -> each instruction takes 8 cycles, results unchanged.
REQ-034 R1=0x10, OUT R2->[R1+4] with port_ack after 2 cycles -> port_addr=0x14, port_we=1, port_wdata=R2, req held 3 cycles.
REQ-035 PC=2, JMP 0xFE -> next fetch addr 0; BR with R[rd]=0 -> PC+1; PC=0xFF, NOP -> PC wraps to 0.
REQ-036 do_reset_n low during IN wait -> port_req drops next edge, rd unchanged, next fetch addr 0.
REQ-037 HALT -> halted=1 after EXEC, no further imem_req for 20 cycles; WRITE to R0 -> reads 0.

Source files
------------

// File: rtl/cpu_core_pkg.sv
// Shared encodings for the cpu_core slice: FSM states, opcodes, ALU operations
// and small decode helpers used by the core.
package cpu_core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_REGLOAD   = 3'd1,
    ST_EXEC      = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_NEXT      = 3'd4,
    ST_HALTED    = 3'd5
  } state_e;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_LOADLO  = 4'h1;
  localparam logic [3:0] OP_IN      = 4'h2;
  localparam logic [3:0] OP_OUT     = 4'h3;
  localparam logic [3:0] OP_JMP     = 4'h4;
  localparam logic [3:0] OP_BR      = 4'h5;
  localparam logic [3:0] OP_HALT    = 4'h6;
  localparam logic [3:0] OP_NOP_ALT = 4'h7;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  // Opcodes 8..15 are ALU operations selected by the low three bits.
  function automatic logic is_alu(input logic [3:0] op);
    return op[3];
  endfunction

  // Opcodes whose result lands in rd during WRITEBACK.
  function automatic logic writes_rd(input logic [3:0] op);
    return op[3] || (op == OP_LOADLO) || (op == OP_IN);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two combinational read ports, one write port, register 0
// hard-wired to zero. All registers clear on reset.
module cpu_regfile
  import cpu_core_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  do_reset_n,
  input  logic [IDX_W-1:0]      raddr_a,
  output logic [WORD_WIDTH-1:0] rdata_a,
  input  logic [IDX_W-1:0]      raddr_b,
  output logic [WORD_WIDTH-1:0] rdata_b,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [WORD_WIDTH-1:0] wdata
);

  logic [WORD_WIDTH-1:0] regs [NUM_REGS];

  // Register 0 has no storage, so writes to it simply vanish.
  assign regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(gi);
      logic [WORD_WIDTH-1:0] reg_q;
      logic [WORD_WIDTH-1:0] reg_d;

      // Take the write data when this register is addressed.
      always_comb begin
        reg_d = reg_q;
        if (we && (waddr == MY_IDX)) reg_d = wdata;
      end

      // Storage flop, cleared by reset.
      always_ff @(posedge clk) begin
        if (!do_reset_n) reg_q <= '0;
        else             reg_q <= reg_d;
      end

      assign regs[gi] = reg_q;
    end
  endgenerate

  // Read ports are plain muxes; the core latches their outputs in REGLOAD.
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
  end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 16-bit-instruction core: FETCH, REGLOAD, EXEC, WRITEBACK, NEXT,
// with handshaked instruction fetch and port I/O, and a sticky HALTED state.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  do_reset_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [15:0]           imem_data,
  output logic                  port_req,
  output logic                  port_we,
  output logic [WORD_WIDTH-1:0] port_addr,
  output logic [WORD_WIDTH-1:0] port_wdata,
  input  logic                  port_ack,
  input  logic [WORD_WIDTH-1:0] port_rdata,
  output logic                  halted,
  output logic [2:0]            state
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           instr_q, instr_d;
  logic [WORD_WIDTH-1:0] a_q, a_d;      // R[ra]
  logic [WORD_WIDTH-1:0] s_q, s_d;      // R[rb], or R[rd] for OUT/BR
  logic [WORD_WIDTH-1:0] res_q, res_d;  // value to write back

  logic [3:0]            op;
  logic [IDX_W-1:0]      rd_idx, ra_idx, rb_idx;
  logic [7:0]            imm8;
  logic [3:0]            imm4;
  logic                  is_port_op;
  logic                  take_jump;
  logic [WORD_WIDTH-1:0] alu_res;
  logic [WORD_WIDTH-1:0] rf_rdata_a, rf_rdata_b;
  logic [IDX_W-1:0]      rf_raddr_b;
  logic                  rf_we;

  assign op         = instr_q[15:12];
  assign rd_idx     = instr_q[8 +: IDX_W];
  assign ra_idx     = instr_q[4 +: IDX_W];
  assign rb_idx     = instr_q[0 +: IDX_W];
  assign imm8       = instr_q[7:0];
  assign imm4       = instr_q[3:0];
  assign is_port_op = (op == OP_IN) || (op == OP_OUT);

  // Only OUT and BR need R[rd], and neither needs R[rb], so the second read
  // port serves both roles and three operands fit in two ports.
  assign rf_raddr_b = ((op == OP_OUT) || (op == OP_BR)) ? rd_idx : rb_idx;
  assign rf_we      = (state_q == ST_WRITEBACK) && writes_rd(op) && do_reset_n;

  cpu_regfile #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_rf (
    .clk        (clk),
    .do_reset_n (do_reset_n),
    .raddr_a    (ra_idx),
    .rdata_a    (rf_rdata_a),
    .raddr_b    (rf_raddr_b),
    .rdata_b    (rf_rdata_b),
    .we         (rf_we),
    .waddr      (rd_idx),
    .wdata      (res_q)
  );

  // ALU on the latched operands; shifts use only R[ra].
  always_comb begin
    alu_res = '0;
    unique case (op[2:0])
      ALU_ADD: alu_res = a_q + s_q;
      ALU_SUB: alu_res = a_q - s_q;
      ALU_AND: alu_res = a_q & s_q;
      ALU_OR:  alu_res = a_q | s_q;
      ALU_XOR: alu_res = a_q ^ s_q;
      ALU_SHL: alu_res = {a_q[WORD_WIDTH-2:0], 1'b0};
      ALU_SHR: alu_res = {1'b0, a_q[WORD_WIDTH-1:1]};
      ALU_SLT: alu_res[0] = (a_q < s_q);
    endcase
  end

  // Next-state logic; HALTED is only left through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (imem_ack) state_d = ST_REGLOAD;
      ST_REGLOAD:   state_d = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_HALT)   state_d = ST_HALTED;
        else if (is_port_op) begin
          if (port_ack) state_d = ST_WRITEBACK;
        end
        else                 state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: state_d = ST_NEXT;
      ST_NEXT:      state_d = ST_FETCH;
      ST_HALTED:    state_d = ST_HALTED;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Datapath registers: instruction, operands, result and PC updates.
  always_comb begin
    instr_d   = instr_q;
    a_d       = a_q;
    s_d       = s_q;
    res_d     = res_q;
    pc_d      = pc_q;
    take_jump = (op == OP_JMP) || ((op == OP_BR) && (s_q != '0));
    case (state_q)
      ST_FETCH:   if (imem_ack) instr_d = imem_data;
      ST_REGLOAD: begin
        a_d = rf_rdata_a;
        s_d = rf_rdata_b;
      end
      ST_EXEC: begin
        if (is_alu(op)) res_d = alu_res;
        else begin
          case (op)
            OP_LOADLO: res_d = WORD_WIDTH'(imm8);
            OP_IN:     if (port_ack) res_d = port_rdata;
            OP_NOP, OP_NOP_ALT, OP_OUT, OP_JMP, OP_BR, OP_HALT: res_d = res_q;
            default:   res_d = res_q;
          endcase
        end
      end
      ST_NEXT: begin
        if (take_jump) pc_d = pc_q + ADDR_WIDTH'($signed(imm8));
        else           pc_d = pc_q + ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // Bus outputs. Requests are gated by reset so that nothing is requested
  // while reset is held, even though the state register already reads FETCH.
  always_comb begin
    imem_req   = (state_q == ST_FETCH) && do_reset_n;
    imem_addr  = pc_q;
    port_req   = (state_q == ST_EXEC) && is_port_op && do_reset_n;
    port_we    = port_req && (op == OP_OUT);
    port_addr  = port_req ? (a_q + WORD_WIDTH'(imm4)) : '0;
    port_wdata = port_we ? s_q : '0;
    halted     = (state_q == ST_HALTED);
    state      = state_q;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!do_reset_n) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      instr_q <= '0;
      a_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      s_q     <= s_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: instruction ROM and port responders with
// programmable ack delay, hand-computed expectations per program.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        do_reset_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        port_req, port_we;
  logic [15:0] port_addr, port_wdata;
  logic        port_ack;
  logic [15:0] port_rdata;
  logic        halted;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [15:0] imem [256];
  int imem_delay = 0, port_delay = 0;
  int imem_wait = 0, port_wait = 0;
  int port_req_cycles = 0, overlap_cnt = 0;
  logic [15:0] in_value = 16'h0000;
  logic [15:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic [7:0]  last_fetch_addr;

  always #5 clk = ~clk;

  cpu_core #(.WORD_WIDTH(16), .NUM_REGS(16), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .do_reset_n (do_reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .port_req   (port_req),
    .port_we    (port_we),
    .port_addr  (port_addr),
    .port_wdata (port_wdata),
    .port_ack   (port_ack),
    .port_rdata (port_rdata),
    .halted     (halted),
    .state      (state_dbg)
  );

  // Responders decide the ack for the current cycle 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    if (imem_req && port_req) overlap_cnt++;
    if (imem_req) begin
      if (imem_wait >= imem_delay) begin
        imem_ack = 1'b1;
        imem_data = imem[imem_addr];
        last_fetch_addr = imem_addr;
        imem_wait = 0;
      end else begin
        imem_ack = 1'b0;
        imem_data = 16'hFFFF;
        imem_wait++;
      end
    end else begin
      imem_ack = 1'b0;
      imem_wait = 0;
    end
    if (port_req) begin
      port_req_cycles++;
      if (port_wait >= port_delay) begin
        port_ack = 1'b1;
        port_rdata = in_value;
        cap_addr = port_addr;
        cap_we = port_we;
        cap_wdata = port_wdata;
        port_wait = 0;
      end else begin
        port_ack = 1'b0;
        port_wait++;
      end
    end else begin
      port_ack = 1'b0;
      port_wait = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("  ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Empty ROM locations hold HALT so a runaway program stops.
  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h6000;
  endtask

  task automatic do_reset();
    do_reset_n = 1'b0;
    step(2);
    do_reset_n = 1'b1;
  endtask

  task automatic wait_halt(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!halted && n < max_cycles) begin
      step(1);
      n++;
    end
    check_eq(tag, {31'd0, halted}, 32'd1);
  endtask

  logic [15:0] alu_exp [13];

  initial begin
    do_reset_n = 1'b0;
    imem_ack = 1'b0;
    imem_data = 16'h0000;
    port_ack = 1'b0;
    port_rdata = 16'h0000;
    clear_imem();

    // Reset values while reset is held.
    step(2);
    check_eq("rst_state", {29'd0, state_dbg}, 32'd0);
    check_eq("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    check_eq("rst_port_req", {31'd0, port_req}, 32'd0);
    check_eq("rst_port_we", {31'd0, port_we}, 32'd0);
    check_eq("rst_port_addr", {16'd0, port_addr}, 32'd0);
    check_eq("rst_port_wdata", {16'd0, port_wdata}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);

    // LOADLO R1,5; LOADLO R2,3; SUB R3,R1,R2 with ack always ready.
    imem[0] = 16'h1105; imem[1] = 16'h1203; imem[2] = 16'h9312;
    imem_delay = 0;
    do_reset();
    step(13);
    check_eq("t1_state_wb", {29'd0, state_dbg}, 32'd3);
    check_eq("t1_r3_before", {16'd0, dut.u_rf.regs[3]}, 32'd0);
    step(2);
    check_eq("t1_state_fetch", {29'd0, state_dbg}, 32'd0);
    check_eq("t1_pc", {24'd0, imem_addr}, 32'd3);
    check_eq("t1_imem_req", {31'd0, imem_req}, 32'd1);
    check_eq("t1_r1", {16'd0, dut.u_rf.regs[1]}, 32'h5);
    check_eq("t1_r3", {16'd0, dut.u_rf.regs[3]}, 32'h2);

    // Same program, three wait cycles per fetch: 8 cycles per instruction.
    imem_delay = 3;
    do_reset();
    step(23);
    check_eq("t2_state_next", {29'd0, state_dbg}, 32'd4);
    step(1);
    check_eq("t2_pc", {24'd0, imem_addr}, 32'd3);
    check_eq("t2_state_fetch", {29'd0, state_dbg}, 32'd0);
    check_eq("t2_r3", {16'd0, dut.u_rf.regs[3]}, 32'h2);
    imem_delay = 0;

    // OUT R2 -> [R1+4] with R1=0x10, R2=0xAB, port ack after 2 wait cycles.
    clear_imem();
    imem[0] = 16'h1110; imem[1] = 16'h12AB; imem[2] = 16'h3214;
    port_delay = 2;
    do_reset();
    port_req_cycles = 0;
    step(14);
    check_eq("t3_port_req_hi", {31'd0, port_req}, 32'd1);
    check_eq("t3_port_addr", {16'd0, port_addr}, 32'h14);
    check_eq("t3_port_we", {31'd0, port_we}, 32'd1);
    check_eq("t3_port_wdata", {16'd0, port_wdata}, 32'hAB);
    step(1);
    check_eq("t3_port_req_drop", {31'd0, port_req}, 32'd0);
    check_eq("t3_state_wb", {29'd0, state_dbg}, 32'd3);
    check_eq("t3_req_cycles", port_req_cycles, 32'd3);
    check_eq("t3_cap_addr", {16'd0, cap_addr}, 32'h14);
    check_eq("t3_cap_wdata", {16'd0, cap_wdata}, 32'hAB);
    check_eq("t3_cap_we", {31'd0, cap_we}, 32'd1);
    wait_halt("t3_halt", 50);

    // PC=2: JMP -2 returns to 0.
    clear_imem();
    imem[0] = 16'h0000; imem[1] = 16'h0000; imem[2] = 16'h40FE;
    do_reset();
    step(10);
    check_eq("t4_pc_at_jmp", {24'd0, imem_addr}, 32'd2);
    step(5);
    check_eq("t4_jmp_target", {24'd0, imem_addr}, 32'd0);
    check_eq("t4_jmp_state", {29'd0, state_dbg}, 32'd0);

    // BR not taken with R5=0, then taken after R5=1.
    clear_imem();
    imem[0] = 16'h5504; imem[1] = 16'h1501; imem[2] = 16'h5504;
    do_reset();
    step(5);
    check_eq("t4_br_not_taken", {24'd0, imem_addr}, 32'd1);
    step(10);
    check_eq("t4_br_taken", {24'd0, imem_addr}, 32'd6);

    // JMP -1 from 0 lands on 0xFF; NOP there wraps the PC to 0.
    clear_imem();
    imem[0] = 16'h40FF; imem[255] = 16'h7000;
    do_reset();
    step(5);
    check_eq("t4_pc_ff", {24'd0, imem_addr}, 32'hFF);
    step(5);
    check_eq("t4_pc_wrap", {24'd0, imem_addr}, 32'd0);

    // Reset during an IN wait aborts it; restart fetches address 0.
    clear_imem();
    imem[0] = 16'h1577; imem[1] = 16'h2503;
    port_delay = 1000;
    in_value = 16'h5A5A;
    do_reset();
    step(8);
    check_eq("t5_in_req", {31'd0, port_req}, 32'd1);
    check_eq("t5_in_addr", {16'd0, port_addr}, 32'h3);
    check_eq("t5_in_we", {31'd0, port_we}, 32'd0);
    check_eq("t5_r5_before", {16'd0, dut.u_rf.regs[5]}, 32'h77);
    do_reset_n = 1'b0;
    step(1);
    check_eq("t5_port_req_drop", {31'd0, port_req}, 32'd0);
    check_eq("t5_state_fetch", {29'd0, state_dbg}, 32'd0);
    check_eq("t5_r5_not_in", {16'd0, dut.u_rf.regs[5]}, 32'h0);
    do_reset_n = 1'b1;
    last_fetch_addr = 8'hAA;
    step(1);
    check_eq("t5_first_fetch", {24'd0, last_fetch_addr}, 32'd0);
    check_eq("t5_state_regload", {29'd0, state_dbg}, 32'd1);
    port_delay = 0;

    // ALU operations on R1=0xF0, R2=0x3C.
    clear_imem();
    imem[0]  = 16'h11F0; imem[1]  = 16'h123C;
    imem[2]  = 16'h8312; imem[3]  = 16'h9412; imem[4]  = 16'hA512;
    imem[5]  = 16'hB612; imem[6]  = 16'hC712; imem[7]  = 16'hD812;
    imem[8]  = 16'hE912; imem[9]  = 16'hFA12; imem[10] = 16'h9B21;
    imem[11] = 16'hFC21;
    alu_exp[3]  = 16'h012C; alu_exp[4]  = 16'h00B4; alu_exp[5]  = 16'h0030;
    alu_exp[6]  = 16'h00FC; alu_exp[7]  = 16'h00CC; alu_exp[8]  = 16'h01E0;
    alu_exp[9]  = 16'h0078; alu_exp[10] = 16'h0000; alu_exp[11] = 16'hFF4C;
    alu_exp[12] = 16'h0001;
    do_reset();
    wait_halt("t6_halt", 200);
    for (int r = 3; r <= 12; r++) begin
      check_eq($sformatf("t6_alu_r%0d", r), {16'd0, dut.u_rf.regs[r]}, {16'd0, alu_exp[r]});
    end

    // Write to R0 is dropped; HALT timing and no fetches while halted.
    clear_imem();
    imem[0] = 16'h1409; imem[1] = 16'h1055; imem[2] = 16'hB400; imem[3] = 16'h6000;
    do_reset();
    step(17);
    check_eq("t7_exec_halted", {31'd0, halted}, 32'd0);
    check_eq("t7_exec_state", {29'd0, state_dbg}, 32'd2);
    step(1);
    check_eq("t7_halted", {31'd0, halted}, 32'd1);
    check_eq("t7_state_halted", {29'd0, state_dbg}, 32'd5);
    check_eq("t7_r0", {16'd0, dut.u_rf.regs[0]}, 32'd0);
    check_eq("t7_r4", {16'd0, dut.u_rf.regs[4]}, 32'd0);
    begin
      int req_seen;
      req_seen = 0;
      for (int c = 0; c < 20; c++) begin
        step(1);
        if (imem_req || port_req) req_seen++;
      end
      check_eq("t7_no_req", req_seen, 32'd0);
    end
    check_eq("t7_still_halted", {31'd0, halted}, 32'd1);
    do_reset_n = 1'b0;
    step(1);
    check_eq("t7_reset_clears_halt", {31'd0, halted}, 32'd0);
    do_reset_n = 1'b1;

    check_eq("req_overlap", overlap_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
